// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants for the multi-cycle MIPS control unit.
//   - Primary opcode values (instr[31:26])
//   - FSM state encoding
//   - Exception cause, memory access size, PC source and ALU op encodings
package ctrl_pkg;

   // Primary opcodes
   localparam logic [5:0] OpRtype = 6'd0;
   localparam logic [5:0] OpJ     = 6'd2;
   localparam logic [5:0] OpBeq   = 6'd4;
   localparam logic [5:0] OpBne   = 6'd5;
   localparam logic [5:0] OpAddi  = 6'd8;
   localparam logic [5:0] OpSlti  = 6'd10;
   localparam logic [5:0] OpSltiu = 6'd11;
   localparam logic [5:0] OpAndi  = 6'd12;
   localparam logic [5:0] OpOri   = 6'd13;
   localparam logic [5:0] OpLb    = 6'd32;
   localparam logic [5:0] OpLh    = 6'd33;
   localparam logic [5:0] OpLw    = 6'd35;
   localparam logic [5:0] OpLbu   = 6'd36;
   localparam logic [5:0] OpLhu   = 6'd37;
   localparam logic [5:0] OpSb    = 6'd40;
   localparam logic [5:0] OpSh    = 6'd41;
   localparam logic [5:0] OpSw    = 6'd43;

   typedef enum logic [2:0] {
      StFetch,
      StDecode,
      StExec,
      StMem,
      StWb,
      StBranch,
      StJump,
      StExc
   } state_e;

   // Exception causes
   localparam logic [1:0] ExcNone     = 2'd0;
   localparam logic [1:0] ExcIllegal  = 2'd1;
   localparam logic [1:0] ExcZeroDest = 2'd2;
   localparam logic [1:0] ExcBusTmo   = 2'd3;

   // Memory access sizes
   localparam logic [1:0] SizeByte = 2'd0;
   localparam logic [1:0] SizeHalf = 2'd1;
   localparam logic [1:0] SizeWord = 2'd2;

   // PC sources
   localparam logic [1:0] PcSrcSeq    = 2'd0;
   localparam logic [1:0] PcSrcBranch = 2'd1;
   localparam logic [1:0] PcSrcJump   = 2'd2;
   localparam logic [1:0] PcSrcExc    = 2'd3;

   // ALU operations
   localparam logic [1:0] AluAdd   = 2'd0;
   localparam logic [1:0] AluSub   = 2'd1;
   localparam logic [1:0] AluFunct = 2'd2;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode classifier.
//   op_i          primary opcode (instr[31:26])
//   rt_i, rd_i    rt (instr[20:16]) and rd (instr[15:11]) fields
//   is_*_o        instruction class flags
//   illegal_o     opcode not in the supported set
//   zero_dest_o   instruction would write register $0 (unqualified)
//   mem_size_o    access size for loads/stores
//   mem_signed_o  sign-extend load data (lb, lh)
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [5:0] op_i,
   input  logic [4:0] rt_i,
   input  logic [4:0] rd_i,
   output logic       is_rtype_o,
   output logic       is_imm_o,
   output logic       is_load_o,
   output logic       is_store_o,
   output logic       is_branch_o,
   output logic       is_jump_o,
   output logic       illegal_o,
   output logic       zero_dest_o,
   output logic [1:0] mem_size_o,
   output logic       mem_signed_o
);

   always_comb begin
      is_rtype_o   = 1'b0;
      is_imm_o     = 1'b0;
      is_load_o    = 1'b0;
      is_store_o   = 1'b0;
      is_branch_o  = 1'b0;
      is_jump_o    = 1'b0;
      illegal_o    = 1'b0;
      mem_size_o   = SizeWord;
      mem_signed_o = 1'b0;
      case (op_i)
         OpRtype:                                     is_rtype_o  = 1'b1;
         OpJ:                                         is_jump_o   = 1'b1;
         OpBeq, OpBne:                                is_branch_o = 1'b1;
         OpAddi, OpSlti, OpSltiu, OpAndi, OpOri:      is_imm_o    = 1'b1;
         OpLb:  begin is_load_o  = 1'b1; mem_size_o = SizeByte; mem_signed_o = 1'b1; end
         OpLh:  begin is_load_o  = 1'b1; mem_size_o = SizeHalf; mem_signed_o = 1'b1; end
         OpLw:  begin is_load_o  = 1'b1; mem_size_o = SizeWord; end
         OpLbu: begin is_load_o  = 1'b1; mem_size_o = SizeByte; end
         OpLhu: begin is_load_o  = 1'b1; mem_size_o = SizeHalf; end
         OpSb:  begin is_store_o = 1'b1; mem_size_o = SizeByte; end
         OpSh:  begin is_store_o = 1'b1; mem_size_o = SizeHalf; end
         OpSw:  begin is_store_o = 1'b1; mem_size_o = SizeWord; end
         default:                                     illegal_o   = 1'b1;
      endcase
   end

   // R-type writes rd; immediate ALU forms and loads write rt.
   assign zero_dest_o = (is_rtype_o && (rd_i == 5'd0)) ||
                        ((is_imm_o || is_load_o) && (rt_i == 5'd0));

endmodule

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle MIPS main control unit.
// Sequences FETCH/DECODE/EXEC/MEM/WB (plus BRANCH, JUMP, EXC) and drives the
// datapath strobes from the current state.
//   clk_i, rst_i      clock; synchronous active-high reset
//   instr_i           instruction register contents
//   mem_ready_i       memory completed the current request
//   mem_*_o, iord_o   shared memory handshake and address select
//   ir_write_o, pc_*  IR load and PC update controls
//   alu_*_o           ALU operand/operation select
//   reg_*_o, mem2reg  register file write controls
//   exception_o       one-cycle exception pulse; exc_code_o holds last cause
module control_fsm
   import ctrl_pkg::*;
#(
   parameter int unsigned ZERO_DEST_EXC = 1,
   parameter int unsigned MEM_TIMEOUT   = 16,
   parameter int unsigned TO_W          = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] instr_i,
   input  logic        mem_ready_i,
   output logic        mem_req_o,
   output logic        iord_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   output logic [1:0]  mem_size_o,
   output logic        mem_signed_o,
   output logic        ir_write_o,
   output logic        pc_write_o,
   output logic        pc_write_cond_o,
   output logic        branch_ne_o,
   output logic [1:0]  pc_src_o,
   output logic        alu_src_b_o,
   output logic [1:0]  alu_op_o,
   output logic        reg_dst_o,
   output logic        reg_write_o,
   output logic        mem2reg_o,
   output logic        exception_o,
   output logic [1:0]  exc_code_o
);

   state_e            state_q, state_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [1:0]        exc_code_q, exc_code_d;

   logic       is_rtype, is_imm, is_load, is_store, is_branch, is_jump;
   logic       illegal, zero_dest, dec_signed;
   logic [1:0] dec_size;
   logic       timeout;
   logic       unused_instr;

   assign unused_instr = ^{instr_i[25:21], instr_i[10:0]};

   ctrl_decode u_decode (
      .op_i         (instr_i[31:26]),
      .rt_i         (instr_i[20:16]),
      .rd_i         (instr_i[15:11]),
      .is_rtype_o   (is_rtype),
      .is_imm_o     (is_imm),
      .is_load_o    (is_load),
      .is_store_o   (is_store),
      .is_branch_o  (is_branch),
      .is_jump_o    (is_jump),
      .illegal_o    (illegal),
      .zero_dest_o  (zero_dest),
      .mem_size_o   (dec_size),
      .mem_signed_o (dec_signed)
   );

   // Last permitted wait cycle; mem_ready in this cycle still wins.
   assign timeout = (to_cnt_q == TO_W'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StFetch;
         to_cnt_q   <= '0;
         exc_code_q <= ExcNone;
      end else begin
         state_q    <= state_d;
         to_cnt_q   <= to_cnt_d;
         exc_code_q <= exc_code_d;
      end
   end

   // Next state. The wait counter only advances while stalled in FETCH/MEM and
   // is zero on every transition, so it is clear on entry to either state.
   always_comb begin
      state_d    = state_q;
      to_cnt_d   = '0;
      exc_code_d = exc_code_q;
      unique case (state_q)
         StFetch, StMem: begin
            if (mem_ready_i) begin
               if (state_q == StFetch) state_d = StDecode;
               else if (is_load)       state_d = StWb;
               else                    state_d = StFetch;
            end else if (timeout) begin
               state_d    = StExc;
               exc_code_d = ExcBusTmo;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         StDecode: begin
            if (illegal) begin
               state_d    = StExc;
               exc_code_d = ExcIllegal;
            end else if ((ZERO_DEST_EXC != 0) && zero_dest) begin
               state_d    = StExc;
               exc_code_d = ExcZeroDest;
            end else if (is_jump) begin
               state_d = StJump;
            end else if (is_branch) begin
               state_d = StBranch;
            end else begin
               state_d = StExec;
            end
         end
         StExec:   state_d = (is_load || is_store) ? StMem : StWb;
         StWb, StBranch, StJump, StExc: state_d = StFetch;
         default:  state_d = StFetch;
      endcase
   end

   // Outputs decoded from state; ir_write/pc_write in FETCH also see mem_ready.
   // Everything is forced low while reset is asserted so an aborted
   // instruction cannot write anything.
   always_comb begin
      mem_req_o       = 1'b0;
      iord_o          = 1'b0;
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      mem_size_o      = SizeByte;
      mem_signed_o    = 1'b0;
      ir_write_o      = 1'b0;
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      branch_ne_o     = 1'b0;
      pc_src_o        = PcSrcSeq;
      alu_src_b_o     = 1'b0;
      alu_op_o        = AluAdd;
      reg_dst_o       = 1'b0;
      reg_write_o     = 1'b0;
      mem2reg_o       = 1'b0;
      exception_o     = 1'b0;
      if (!rst_i) begin
         unique case (state_q)
            StFetch: begin
               mem_req_o  = 1'b1;
               mem_read_o = 1'b1;
               mem_size_o = SizeWord;
               ir_write_o = mem_ready_i;
               pc_write_o = mem_ready_i;
            end
            StDecode: ;
            StExec: begin
               if (is_load || is_store) begin
                  alu_op_o    = AluAdd;
                  alu_src_b_o = 1'b1;
               end else begin
                  alu_op_o    = AluFunct;
                  alu_src_b_o = is_imm;
               end
            end
            StMem: begin
               mem_req_o    = 1'b1;
               iord_o       = 1'b1;
               mem_read_o   = is_load;
               mem_write_o  = is_store;
               mem_size_o   = dec_size;
               mem_signed_o = dec_signed;
            end
            StWb: begin
               reg_write_o = 1'b1;
               reg_dst_o   = is_rtype;
               mem2reg_o   = !is_load;
            end
            StBranch: begin
               alu_op_o        = AluSub;
               pc_write_cond_o = 1'b1;
               pc_src_o        = PcSrcBranch;
               branch_ne_o     = (instr_i[31:26] == OpBne);
            end
            StJump: begin
               pc_write_o = 1'b1;
               pc_src_o   = PcSrcJump;
            end
            StExc: begin
               exception_o = 1'b1;
               pc_write_o  = 1'b1;
               pc_src_o    = PcSrcExc;
            end
            default: ;
         endcase
      end
   end

   assign exc_code_o = exc_code_q;

endmodule
